// File: rtl/spi_pkg.sv
// Shared types and constants for the clock-domain SPI slave.
package spi_pkg;

   // Frame-level state of the slave.
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // SCK idles high when CPOL equals this value.
   localparam bit CPOL_HIGH = 1'b1;
   // Sample on the leading edge, shift on the trailing edge.
   localparam bit CPHA_LEAD = 1'b0;

   // Flops in each input synchroniser chain (edge-detect register is extra).
   localparam int unsigned SYNC_DEPTH = 2;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous input plus rise/fall detection.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  dly_q;

   // Synchroniser chain plus one delayed copy for edge comparison.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_DEPTH{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
         dly_q  <= sync_q[SYNC_DEPTH-1];
      end
   end

   assign rise_c =  sync_q[SYNC_DEPTH-1] & ~dly_q;
   assign fall_c = ~sync_q[SYNC_DEPTH-1] &  dly_q;

endmodule : spi_sync_edge

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on clk: single-clock receive and reply handshake.
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int unsigned            DATA_LENGTH = 8,
   parameter bit                     CPOL        = 1'b1,
   parameter bit                     CPHA        = 1'b0,
   parameter logic [DATA_LENGTH-1:0] IDLE_TX     = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ss_n,
   input  logic                   sck,
   input  logic                   mosi,
   output logic                   miso,
   output logic                   miso_oe,
   input  logic [DATA_LENGTH-1:0] tx_data,
   input  logic                   tx_load,
   output logic                   tx_ready,
   output logic [DATA_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   tx_underrun,
   output logic                   frame_err
);

   localparam int unsigned CNT_W = $clog2(DATA_LENGTH);

   logic                   ss_rise_c, ss_fall_c, sck_rise_c, sck_fall_c;
   logic [SYNC_DEPTH-1:0]  mosi_q;
   logic                   mosi_s_c;
   logic                   lead_c, trail_c, sample_c, shift_c;
   logic                   start_c, run_c, reload_c, commit_c;
   logic                   consume_c, underrun_c;
   logic [DATA_LENGTH-1:0] next_word_c, rx_word_c;

   state_e                 state_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [DATA_LENGTH-1:0] rx_shift_q, tx_shift_q, rx_data_q, buf_q;
   logic                   tx_ready_q, miso_q, miso_oe_q;
   logic                   rx_valid_q, tx_underrun_q, frame_err_q;
   logic                   first_q, pending_q, peek_empty_q;

   spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(sck),
      .rise_c (sck_rise_c),
      .fall_c (sck_fall_c)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(ss_n),
      .rise_c (ss_rise_c),
      .fall_c (ss_fall_c)
   );

   // MOSI needs only the level, aligned with the SCK edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_q <= '0;
      else        mosi_q <= {mosi_q[SYNC_DEPTH-2:0], mosi};
   end

   // Decode edges and frame events; the CPHA=0 reload is a peek that is
   // only committed once the following frame really samples its first bit.
   always_comb begin
      mosi_s_c    = mosi_q[SYNC_DEPTH-1];
      lead_c      = (CPOL == CPOL_HIGH) ? sck_fall_c : sck_rise_c;
      trail_c     = (CPOL == CPOL_HIGH) ? sck_rise_c : sck_fall_c;
      sample_c    = (CPHA == CPHA_LEAD) ? lead_c  : trail_c;
      shift_c     = (CPHA == CPHA_LEAD) ? trail_c : lead_c;
      start_c     = (state_q == ST_IDLE) && ss_fall_c;
      run_c       = (state_q == ST_ACTIVE) && !ss_rise_c;
      reload_c    = run_c && shift_c && (bit_cnt_q == '0) &&
                    ((CPHA == CPHA_LEAD) || !first_q);
      commit_c    = run_c && sample_c && pending_q;
      next_word_c = tx_ready_q ? IDLE_TX : buf_q;
      rx_word_c   = {rx_shift_q[DATA_LENGTH-2:0], mosi_s_c};
      if (CPHA == CPHA_LEAD) begin
         consume_c  = (start_c && !tx_ready_q) || (commit_c && !peek_empty_q);
         underrun_c = (start_c &&  tx_ready_q) || (commit_c &&  peek_empty_q);
      end else begin
         consume_c  = (start_c || reload_c) && !tx_ready_q;
         underrun_c = (start_c || reload_c) &&  tx_ready_q;
      end
   end

   // Reply buffer: a frame start frees it before a same-cycle load is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         tx_ready_q <= 1'b1;
      end else begin
         if (consume_c) tx_ready_q <= 1'b1;
         if (tx_load && tx_ready_q) begin
            buf_q      <= tx_data;
            tx_ready_q <= 1'b0;
         end
      end
   end

   // Frame FSM with the RX/TX shifters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         rx_data_q     <= '0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_err_q   <= 1'b0;
         first_q       <= 1'b0;
         pending_q     <= 1'b0;
         peek_empty_q  <= 1'b0;
      end else begin
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         tx_underrun_q <= underrun_c;
         case (state_q)
            ST_IDLE: begin
               miso_q <= 1'b0;
               if (ss_fall_c) begin
                  state_q    <= ST_ACTIVE;
                  miso_oe_q  <= 1'b1;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  first_q    <= 1'b1;
                  pending_q  <= 1'b0;
                  tx_shift_q <= next_word_c;
                  if (CPHA == CPHA_LEAD) miso_q <= next_word_c[DATA_LENGTH-1];
               end
            end
            ST_ACTIVE: begin
               if (ss_rise_c) begin
                  state_q     <= ST_IDLE;
                  miso_oe_q   <= 1'b0;
                  miso_q      <= 1'b0;
                  frame_err_q <= (bit_cnt_q != '0);
                  bit_cnt_q   <= '0;
                  rx_shift_q  <= '0;
                  tx_shift_q  <= '0;
                  first_q     <= 1'b0;
                  pending_q   <= 1'b0;
               end else begin
                  if (sample_c) begin
                     rx_shift_q <= rx_word_c;
                     pending_q  <= 1'b0;
                     if (bit_cnt_q == CNT_W'(DATA_LENGTH - 1)) begin
                        rx_data_q  <= rx_word_c;
                        rx_valid_q <= 1'b1;
                        bit_cnt_q  <= '0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
                  if (shift_c) begin
                     if (reload_c) begin
                        tx_shift_q   <= next_word_c;
                        miso_q       <= next_word_c[DATA_LENGTH-1];
                        pending_q    <= (CPHA == CPHA_LEAD);
                        peek_empty_q <= tx_ready_q;
                     end else if (bit_cnt_q == '0) begin
                        miso_q  <= tx_shift_q[DATA_LENGTH-1];
                        first_q <= 1'b0;
                     end else begin
                        tx_shift_q <= {tx_shift_q[DATA_LENGTH-2:0], 1'b0};
                        miso_q     <= tx_shift_q[DATA_LENGTH-2];
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = tx_underrun_q;
   assign frame_err   = frame_err_q;

endmodule : spi_slave_sync

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances (one per CPOL/CPHA mode) share one
// master; a buffer/frame model predicts replies, received words and pulses.
module tb_spi_slave_sync;

   localparam int unsigned H    = 8;
   localparam logic [7:0]  IDLE = 8'h96;

   logic clk = 1'b0;
   logic rst_n, ss_n, sclk, mosi, tx_load;
   logic [7:0] tx_data;
   logic [3:0] sck_v, miso_v, oe_v, rdy_v, rxv_v, und_v, ferr_v;
   logic [7:0] rxd [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit P_CPOL = ((g / 2) == 1);
      localparam bit P_CPHA = ((g % 2) == 1);
      assign sck_v[g] = sclk ^ P_CPOL;
      spi_slave_sync #(
         .DATA_LENGTH(8), .CPOL(P_CPOL), .CPHA(P_CPHA), .IDLE_TX(IDLE)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .sck(sck_v[g]), .mosi(mosi),
         .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(tx_data),
         .tx_load(tx_load), .tx_ready(rdy_v[g]), .rx_data(rxd[g]),
         .rx_valid(rxv_v[g]), .tx_underrun(und_v[g]), .frame_err(ferr_v[g])
      );
   end

   int n_checks = 0;
   int n_err    = 0;
   int nvalid [4];
   int nund   [4];
   int nferr  [4];
   int v0 [4];
   int u0 [4];
   int f0 [4];
   logic [7:0] got [4];

   // Reference model: one-word reply buffer and last received word.
   bit         m_full;
   logic [7:0] m_buf, m_rx;

   initial for (int m = 0; m < 4; m++) begin nvalid[m] = 0; nund[m] = 0; nferr[m] = 0; end

   always @(negedge clk) begin
      for (int m = 0; m < 4; m++) begin
         if (rxv_v[m] === 1'b1) nvalid[m]++;
         if (und_v[m] === 1'b1) nund[m]++;
         if (ferr_v[m] === 1'b1) nferr[m]++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      for (int m = 0; m < 4; m++) begin v0[m] = nvalid[m]; u0[m] = nund[m]; f0[m] = nferr[m]; end
   endtask

   task automatic load_word(input logic [7:0] w);
      tx_data = w; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
      if (!m_full) begin m_full = 1'b1; m_buf = w; end
   endtask

   // A frame starts: reply is the buffered word if any, else the idle word.
   task automatic model_start(output logic [7:0] rep, output int und);
      if (m_full) begin rep = m_buf; und = 0; end
      else begin rep = IDLE; und = 1; end
      m_full = 1'b0;
   endtask

   // Master side: mosi changes mid-idle-phase, miso sampled just before the
   // edge on which that mode's master samples.
   task automatic shift_frame(input logic [7:0] w, input int nbits);
      for (int m = 0; m < 4; m++) got[m] = '0;
      for (int i = 0; i < nbits; i++) begin
         cyc(H / 2); mosi = w[7 - i]; cyc(H / 2);
         for (int m = 0; m < 4; m++) if (m % 2 == 0) got[m][7 - i] = miso_v[m];
         sclk = 1'b1; cyc(H);
         for (int m = 0; m < 4; m++) if (m % 2 == 1) got[m][7 - i] = miso_v[m];
         sclk = 1'b0;
      end
      cyc(H);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
      m_full = 1'b0; m_buf = '0; m_rx = '0;
      cyc(3); rst_n = 1'b1; cyc(2);
      snap();
      for (int k = 0; k < 6; k++) begin sclk = ~sclk; mosi = ~mosi; cyc(H); end
      sclk = 1'b0; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (oe_v[m] !== 1'b0) begin n_err++; $display("FAIL reset.miso_oe m%0d got %b want 0", m, oe_v[m]); end
         n_checks++; if (miso_v[m] !== 1'b0) begin n_err++; $display("FAIL reset.miso m%0d got %b want 0", m, miso_v[m]); end
         n_checks++; if (rdy_v[m] !== 1'b1) begin n_err++; $display("FAIL reset.tx_ready m%0d got %b want 1", m, rdy_v[m]); end
         n_checks++; if (rxd[m] !== 8'h00) begin n_err++; $display("FAIL reset.rx_data m%0d got %h want 00", m, rxd[m]); end
         n_checks++;
         if ((nvalid[m] - v0[m]) + (nund[m] - u0[m]) + (nferr[m] - f0[m]) != 0) begin
            n_err++; $display("FAIL reset.pulses m%0d got %0d want 0", m,
                              (nvalid[m] - v0[m]) + (nund[m] - u0[m]) + (nferr[m] - f0[m]));
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] rep;
      int         und;
      load_word(8'hA5);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (rdy_v[m] !== 1'b0) begin n_err++; $display("FAIL single.loaded m%0d got %b want 0", m, rdy_v[m]); end
      end
      snap();
      ss_n = 1'b0; model_start(rep, und); cyc(6);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (rdy_v[m] !== 1'b1) begin n_err++; $display("FAIL single.ready_at_start m%0d got %b want 1", m, rdy_v[m]); end
         n_checks++; if (oe_v[m] !== 1'b1) begin n_err++; $display("FAIL single.miso_oe m%0d got %b want 1", m, oe_v[m]); end
      end
      sclk = 1'b0; shift_frame(8'h4D, 8); m_rx = 8'h4D;
      ss_n = 1'b1; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (got[m] !== rep) begin n_err++; $display("FAIL single.reply m%0d got %h want %h", m, got[m], rep); end
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL single.rx_data m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (nvalid[m] - v0[m] != 1) begin n_err++; $display("FAIL single.rx_valid m%0d got %0d want 1", m, nvalid[m] - v0[m]); end
         n_checks++; if (nund[m] - u0[m] != und) begin n_err++; $display("FAIL single.underrun m%0d got %0d want %0d", m, nund[m] - u0[m], und); end
         n_checks++; if (oe_v[m] !== 1'b0) begin n_err++; $display("FAIL single.oe_after m%0d got %b want 0", m, oe_v[m]); end
      end
   endtask

   task automatic test_mode_sweep();
      logic [7:0] rep, mw, rw;
      int         und;
      for (int it = 0; it < 5; it++) begin
         rw = (it == 0) ? 8'hC3 : 8'($urandom_range(0, 255));
         mw = (it == 0) ? 8'h3C : 8'($urandom_range(0, 255));
         load_word(rw);
         snap();
         ss_n = 1'b0; model_start(rep, und);
         shift_frame(mw, 8); m_rx = mw;
         ss_n = 1'b1; cyc(H);
         for (int m = 0; m < 4; m++) begin
            n_checks++; if (got[m] !== rep) begin n_err++; $display("FAIL sweep%0d.reply m%0d got %h want %h", it, m, got[m], rep); end
            n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL sweep%0d.rx_data m%0d got %h want %h", it, m, rxd[m], m_rx); end
            n_checks++; if (nvalid[m] - v0[m] != 1) begin n_err++; $display("FAIL sweep%0d.rx_valid m%0d got %0d want 1", it, m, nvalid[m] - v0[m]); end
            n_checks++; if (nund[m] - u0[m] != und) begin n_err++; $display("FAIL sweep%0d.underrun m%0d got %0d want %0d", it, m, nund[m] - u0[m], und); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rep1, rep2, w2;
      int         und1, und2;
      w2 = 8'h02;
      load_word(8'h11);
      snap();
      ss_n = 1'b0; model_start(rep1, und1);
      shift_frame(8'h01, 8); m_rx = 8'h01;
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (got[m] !== rep1) begin n_err++; $display("FAIL b2b.reply1 m%0d got %h want %h", m, got[m], rep1); end
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL b2b.rx1 m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (nund[m] - u0[m] != und1) begin n_err++; $display("FAIL b2b.underrun1 m%0d got %0d want %0d", m, nund[m] - u0[m], und1); end
      end
      model_start(rep2, und2);
      shift_frame(w2, 8); m_rx = w2;
      ss_n = 1'b1; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (got[m] !== rep2) begin n_err++; $display("FAIL b2b.reply2 m%0d got %h want %h", m, got[m], rep2); end
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL b2b.rx2 m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (nvalid[m] - v0[m] != 2) begin n_err++; $display("FAIL b2b.rx_valid m%0d got %0d want 2", m, nvalid[m] - v0[m]); end
         n_checks++; if (nund[m] - u0[m] != und1 + und2) begin n_err++; $display("FAIL b2b.underrun m%0d got %0d want %0d", m, nund[m] - u0[m], und1 + und2); end
         n_checks++; if (nferr[m] - f0[m] != 0) begin n_err++; $display("FAIL b2b.frame_err m%0d got %0d want 0", m, nferr[m] - f0[m]); end
      end
   endtask

   task automatic test_abort();
      logic [7:0] rep, pw;
      int         und;
      pw = 8'($urandom_range(0, 255));
      snap();
      ss_n = 1'b0; model_start(rep, und);
      shift_frame(pw, 5);
      ss_n = 1'b1; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (nferr[m] - f0[m] != 1) begin n_err++; $display("FAIL abort.frame_err m%0d got %0d want 1", m, nferr[m] - f0[m]); end
         n_checks++; if (nvalid[m] - v0[m] != 0) begin n_err++; $display("FAIL abort.rx_valid m%0d got %0d want 0", m, nvalid[m] - v0[m]); end
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL abort.rx_held m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (nund[m] - u0[m] != und) begin n_err++; $display("FAIL abort.underrun m%0d got %0d want %0d", m, nund[m] - u0[m], und); end
      end
      snap();
      ss_n = 1'b0; model_start(rep, und);
      shift_frame(8'hF0, 8); m_rx = 8'hF0;
      ss_n = 1'b1; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL abort.next_rx m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (got[m] !== rep) begin n_err++; $display("FAIL abort.next_reply m%0d got %h want %h", m, got[m], rep); end
         n_checks++; if (nferr[m] - f0[m] != 0) begin n_err++; $display("FAIL abort.next_err m%0d got %0d want 0", m, nferr[m] - f0[m]); end
      end
   endtask

   task automatic test_load_collision();
      logic [7:0] rep, mw;
      int         und;
      mw = 8'($urandom_range(0, 255));
      load_word(8'h77);
      tx_data = 8'hEE; tx_load = 1'b1; cyc(5); tx_load = 1'b0;
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (rdy_v[m] !== 1'b0) begin n_err++; $display("FAIL collide.ready m%0d got %b want 0", m, rdy_v[m]); end
      end
      snap();
      ss_n = 1'b0; model_start(rep, und);
      shift_frame(mw, 8); m_rx = mw;
      ss_n = 1'b1; cyc(H);
      for (int m = 0; m < 4; m++) begin
         n_checks++; if (got[m] !== rep) begin n_err++; $display("FAIL collide.reply m%0d got %h want %h", m, got[m], rep); end
         n_checks++; if (rdy_v[m] !== !m_full) begin n_err++; $display("FAIL collide.ready_after m%0d got %b want %b", m, rdy_v[m], !m_full); end
         n_checks++; if (nund[m] - u0[m] != und) begin n_err++; $display("FAIL collide.underrun m%0d got %0d want %0d", m, nund[m] - u0[m], und); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] rep;
      int         und;
      ss_n = 1'b0; model_start(rep, und);
      shift_frame(8'hAB, 3);
      snap();
      rst_n = 1'b0; cyc(2); ss_n = 1'b1; cyc(2); rst_n = 1'b1;
      m_full = 1'b0; m_rx = '0;
      cyc(3 * H);
      for (int m = 0; m < 4; m++) begin
         n_checks++;
         if ((nvalid[m] - v0[m]) + (nund[m] - u0[m]) + (nferr[m] - f0[m]) != 0) begin
            n_err++; $display("FAIL midreset.pulses m%0d got %0d want 0", m,
                              (nvalid[m] - v0[m]) + (nund[m] - u0[m]) + (nferr[m] - f0[m]));
         end
         n_checks++; if (rxd[m] !== m_rx) begin n_err++; $display("FAIL midreset.rx_data m%0d got %h want %h", m, rxd[m], m_rx); end
         n_checks++; if (oe_v[m] !== 1'b0) begin n_err++; $display("FAIL midreset.oe m%0d got %b want 0", m, oe_v[m]); end
         n_checks++; if (rdy_v[m] !== 1'b1) begin n_err++; $display("FAIL midreset.ready m%0d got %b want 1", m, rdy_v[m]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mode_sweep();
      test_back_to_back();
      test_abort();
      test_load_collision();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_spi_slave_sync
